// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words.
// Each word's immediate is checked for range and alignment, and accepted
// words are streamed to instruction memory at consecutive addresses.
// Rejected inputs are consumed and raise a sticky error.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iRestart,
    input  logic        iValid,
    output logic        oReady,
    input  logic [6:0]  iOpcode,
    input  logic [4:0]  iRd,
    input  logic [4:0]  iRs1,
    input  logic [4:0]  iRs2,
    input  logic [2:0]  iFunct3,
    input  logic [6:0]  iFunct7,
    input  logic [31:0] iImm,
    output logic        oWrEn,
    output logic [31:0] oAddr,
    output logic [31:0] oWord,
    input  logic        iMemReady,
    output logic [15:0] oCount,
    output logic        oErr,
    output logic [6:0]  oErrOp
);

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic        wr_en_reg;
    logic [31:0] addr_reg;
    logic [31:0] word_reg;
    logic [15:0] count_reg;
    logic        err_reg;
    logic [6:0]  err_op_reg;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        accept;
    logic        load;
    logic        done;

    // A value fits an N-bit signed field when all bits above N-2 equal the sign.
    assign fits12 = (&iImm[31:11]) || !(|iImm[31:11]);
    assign fits13 = (&iImm[31:12]) || !(|iImm[31:12]);
    assign fits21 = (&iImm[31:20]) || !(|iImm[31:20]);

    assign oReady = !iRestart && (!wr_en_reg || iMemReady);
    assign accept = iValid && oReady;
    assign load   = accept && enc_ok;
    assign done   = wr_en_reg && iMemReady;

    // Format selection and immediate legality by opcode; unknown opcodes are illegal.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (iOpcode)
            OPC_RTYPE: begin
                enc_word = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode};
                enc_ok   = 1'b1;
            end
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                enc_word = {iImm[11:0], iRs1, iFunct3, iRd, iOpcode};
                enc_ok   = fits12;
            end
            OPC_STORE: begin
                enc_word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpcode};
                enc_ok   = fits12;
            end
            OPC_BRANCH: begin
                enc_word = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3,
                            iImm[4:1], iImm[11], iOpcode};
                enc_ok   = fits13 && !iImm[0];
            end
            OPC_JAL: begin
                enc_word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, iOpcode};
                enc_ok   = fits21 && !iImm[0];
            end
            OPC_LUI: begin
                enc_word = {iImm[31:12], iRd, iOpcode};
                enc_ok   = (iImm[11:0] == 12'd0);
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Output stage, address/count advance on completed writes, sticky error capture.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            wr_en_reg  <= 1'b0;
            addr_reg   <= BASE_ADDR;
            word_reg   <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            err_op_reg <= '0;
        end else if (iRestart) begin
            wr_en_reg  <= 1'b0;
            addr_reg   <= BASE_ADDR;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            err_op_reg <= '0;
        end else begin
            if (done) begin
                addr_reg <= addr_reg + ADDR_STEP;
                if (count_reg != 16'hFFFF) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
            if (load) begin
                word_reg  <= enc_word;
                wr_en_reg <= 1'b1;
            end else if (done) begin
                wr_en_reg <= 1'b0;
            end
            if (accept && !enc_ok) begin
                err_reg <= 1'b1;
                if (!err_reg) begin
                    err_op_reg <= iOpcode;
                end
            end
        end
    end

    assign oWrEn  = wr_en_reg;
    assign oAddr  = addr_reg;
    assign oWord  = word_reg;
    assign oCount = count_reg;
    assign oErr   = err_reg;
    assign oErrOp = err_op_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic checked
// against a field-arithmetic reference model. A second instance with a base
// address just below 2^32 exercises address wrap on the same stimulus.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] IM_OP  = 7'b0010011;
    localparam logic [6:0] JR_OP  = 7'b1100111;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JL_OP  = 7'b1101111;
    localparam logic [6:0] LU_OP  = 7'b0110111;
    localparam logic [6:0] AU_OP  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n, restart, valid, mem_rdy;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;

    logic        ready, wr_en, err;
    logic [31:0] addr, word;
    logic [15:0] count;
    logic [6:0]  err_op;

    logic        w_ready, w_wr_en, w_err;
    logic [31:0] w_addr, w_word;
    logic [15:0] w_count;
    logic [6:0]  w_err_op;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .iCLK(clk), .iRST(rst_n), .iRestart(restart), .iValid(valid), .oReady(ready),
        .iOpcode(opcode), .iRd(rd), .iRs1(rs1), .iRs2(rs2), .iFunct3(f3), .iFunct7(f7),
        .iImm(imm), .oWrEn(wr_en), .oAddr(addr), .oWord(word), .iMemReady(mem_rdy),
        .oCount(count), .oErr(err), .oErrOp(err_op)
    );

    instr_encoder #(.BASE_ADDR(WBASE), .ADDR_STEP(32'd4)) u_wrap (
        .iCLK(clk), .iRST(rst_n), .iRestart(restart), .iValid(valid), .oReady(w_ready),
        .iOpcode(opcode), .iRd(rd), .iRs1(rs1), .iRs2(rs2), .iFunct3(f3), .iFunct7(f7),
        .iImm(imm), .oWrEn(w_wr_en), .oAddr(w_addr), .oWord(w_word), .iMemReady(mem_rdy),
        .oCount(w_count), .oErr(w_err), .oErrOp(w_err_op)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // Reference model state
    logic        m_wren;
    logic [31:0] m_word, m_addr;
    logic [15:0] m_count;
    logic        m_err;
    logic [6:0]  m_errop;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(logic [6:0] op, logic [31:0] im);
        int s;
        s = int'($signed(im));
        case (op)
            R_OP:                      return 1'b1;
            LD_OP, IM_OP, JR_OP, ST_OP: return (s >= -2048) && (s <= 2047);
            BR_OP:                     return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            JL_OP:                     return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
            LU_OP:                     return (im % 4096) == 0;
            default:                   return 1'b0;
        endcase
    endfunction

    // Builds the word by placing each field value at its bit weight.
    function automatic logic [31:0] encode(logic [6:0] op, logic [4:0] d, logic [4:0] a,
                                           logic [4:0] b, logic [2:0] fn3, logic [6:0] fn7,
                                           logic [31:0] im);
        longint unsigned u, w, base;
        u    = 64'(im);
        base = 64'(op);
        case (op)
            R_OP:
                w = 64'(fn7) * 2**25 + 64'(b) * 2**20 + 64'(a) * 2**15
                  + 64'(fn3) * 2**12 + 64'(d) * 2**7 + base;
            LD_OP, IM_OP, JR_OP:
                w = (u % 4096) * 2**20 + 64'(a) * 2**15 + 64'(fn3) * 2**12
                  + 64'(d) * 2**7 + base;
            ST_OP:
                w = ((u / 32) % 128) * 2**25 + 64'(b) * 2**20 + 64'(a) * 2**15
                  + 64'(fn3) * 2**12 + (u % 32) * 2**7 + base;
            BR_OP:
                w = ((u / 4096) % 2) * 2**31 + ((u / 32) % 64) * 2**25
                  + 64'(b) * 2**20 + 64'(a) * 2**15 + 64'(fn3) * 2**12
                  + ((u / 2) % 16) * 2**8 + ((u / 2048) % 2) * 2**7 + base;
            JL_OP:
                w = ((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21
                  + ((u / 2048) % 2) * 2**20 + ((u / 4096) % 256) * 2**12
                  + 64'(d) * 2**7 + base;
            LU_OP:
                w = (u / 4096) * 4096 + 64'(d) * 2**7 + base;
            default:
                w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_wren  = 1'b0;
        m_word  = 32'd0;
        m_addr  = BASE;
        m_count = 16'd0;
        m_err   = 1'b0;
        m_errop = 7'd0;
    endtask

    task automatic check_state(string tag);
        check({tag, "_wren"},   32'(wr_en),   32'(m_wren));
        check({tag, "_word"},   word,         m_word);
        check({tag, "_addr"},   addr,         m_addr);
        check({tag, "_count"},  32'(count),   32'(m_count));
        check({tag, "_err"},    32'(err),     32'(m_err));
        check({tag, "_errop"},  32'(err_op),  32'(m_errop));
        check({tag, "_waddr"},  w_addr,       m_addr - BASE + WBASE);
        check({tag, "_wcount"}, 32'(w_count), 32'(m_count));
        check({tag, "_wword"},  w_word,       m_word);
        check({tag, "_werr"},   32'({w_wr_en, w_err, w_err_op}), 32'({m_wren, m_err, m_errop}));
    endtask

    // One clock: drive inputs, check oReady, advance the model, check registered outputs.
    task automatic cycle(bit v, logic [6:0] op, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                         logic [2:0] fn3, logic [6:0] fn7, logic [31:0] im,
                         bit mr, bit rn, bit rs, string tag);
        bit exp_ready, acc, ok, done;
        valid = v; opcode = op; rd = d; rs1 = a; rs2 = b; f3 = fn3; f7 = fn7; imm = im;
        mem_rdy = mr; rst_n = rn; restart = rs;
        #1;
        exp_ready = !rs && (!m_wren || mr);
        check({tag, "_ready"},  32'(ready),   32'(exp_ready));
        check({tag, "_wready"}, 32'(w_ready), 32'(exp_ready));
        acc  = v && exp_ready;
        ok   = legal(op, im);
        done = m_wren && mr;
        if (!rn) begin
            model_reset();
        end else if (rs) begin
            m_wren = 1'b0; m_addr = BASE; m_count = 16'd0; m_err = 1'b0; m_errop = 7'd0;
        end else begin
            if (done) begin
                m_addr = m_addr + 32'd4;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
            if (acc && ok) begin
                m_word = encode(op, d, a, b, fn3, fn7, im);
                m_wren = 1'b1;
            end else if (done) begin
                m_wren = 1'b0;
            end
            if (acc && !ok) begin
                if (!m_err) m_errop = op;
                m_err = 1'b1;
            end
        end
        if (verbose && rn && !rs && acc)
            $display("%s: op=%b imm=%h -> %s word=%h addr=%h count=%0d", tag, op, im,
                     ok ? "accepted" : "rejected", m_word, m_addr, m_count);
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic send(logic [6:0] op, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                        logic [2:0] fn3, logic [31:0] im, bit mr, string tag);
        cycle(1'b1, op, d, a, b, fn3, 7'd0, im, mr, 1'b1, 1'b0, tag);
    endtask

    task automatic idle(bit mr, string tag);
        cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, mr, 1'b1, 1'b0, tag);
    endtask

    logic [6:0]  op_tab [10];
    logic [31:0] imm_tab [16];

    initial begin
        op_tab = '{R_OP, LD_OP, IM_OP, JR_OP, ST_OP, BR_OP, JL_OP, LU_OP, AU_OP, 7'b1111111};
        imm_tab = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, 32'd4096,
                    -32'sd4096, -32'sd4097, 32'd1048574, 32'd1048575, 32'd1048576,
                    -32'sd1048576, -32'sd1048578, 32'd0, 32'h1234_5000};

        // Reset
        rst_n = 1'b0; restart = 1'b0; valid = 1'b0; mem_rdy = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_state("reset");
        check("reset_addr_const", addr, 32'h0040_0000);

        // Encoding and address sequence
        send(IM_OP, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, "addi");
        check("addi_word_const", word, 32'h0050_0093);
        check("addi_addr_const", addr, 32'h0040_0000);
        send(ST_OP, 5'd0, 5'd1, 5'd2, 3'b010, 32'd4, 1'b1, "sw");
        check("sw_word_const", word, 32'h0020_A223);
        check("sw_addr_const", addr, 32'h0040_0004);
        idle(1'b1, "drain1");
        check("count2_const", 32'(count), 32'd2);
        check("wrap_addr_const", w_addr, 32'h0000_0000);

        // Jump and upper-immediate
        send(LU_OP, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b1, "lui");
        check("lui_word_const", word, 32'h1234_52B7);
        send(JL_OP, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1, "jal");
        check("jal_word_const", word, 32'h0000_006F);
        idle(1'b1, "drain2");

        // Backpressure: five stalled cycles, then completion plus reload at one edge
        send(IM_OP, 5'd3, 5'd3, 5'd0, 3'd0, 32'd100, 1'b1, "bp_first");
        for (int i = 0; i < 5; i++)
            send(R_OP, 5'd4, 5'd3, 5'd2, 3'd0, 32'd0, 1'b0, "bp_stall");
        send(R_OP, 5'd4, 5'd3, 5'd2, 3'd0, 32'd0, 1'b1, "bp_release");
        idle(1'b1, "drain3");

        // Range rejection
        send(IM_OP, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1, "addi_2048");
        check("rej_errop_const", 32'(err_op), 32'(IM_OP));
        send(BR_OP, 5'd0, 5'd1, 5'd2, 3'd0, 32'd6, 1'b1, "beq_6");
        send(BR_OP, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5, 1'b1, "beq_5");
        check("rej_errop_kept", 32'(err_op), 32'(IM_OP));
        idle(1'b1, "drain4");

        // Restart with a word pending
        send(IM_OP, 5'd7, 5'd0, 5'd0, 3'd0, 32'd1, 1'b1, "rs_load");
        idle(1'b0, "rs_hold");
        cycle(1'b1, IM_OP, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b1, 1'b1, "restart");
        check("restart_addr_const", addr, 32'h0040_0000);
        // Reset with a word pending
        send(IM_OP, 5'd7, 5'd0, 5'd0, 3'd0, 32'd1, 1'b1, "rst_load");
        idle(1'b0, "rst_hold");
        cycle(1'b1, IM_OP, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b0, 1'b0, "reset2");
        // Reset together with restart
        send(IM_OP, 5'd9, 5'd0, 5'd0, 3'd0, 32'd9, 1'b1, "rr_load");
        cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1, "reset_restart");
        check("rr_word_const", word, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r_imm;
            logic [6:0]  r_op;
            int          cls;
            r_op = op_tab[$urandom_range(0, 9)];
            if (r_op == 7'b1111111) r_op = 7'($urandom);
            cls = int'($urandom_range(0, 4));
            case (cls)
                0: r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: r_imm = imm_tab[$urandom_range(0, 15)];
                2: r_imm = $urandom;
                3: r_imm = $urandom & 32'hFFFF_F000;
                default: r_imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            endcase
            cycle($urandom_range(0, 3) != 0, r_op, 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), r_imm, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 79) != 0, $urandom_range(0, 49) == 0, "rand");
        end

        // Count saturation
        cycle(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 1'b1, "sat_restart");
        verbose = 1'b0;
        for (int i = 0; i < 65537; i++)
            send(IM_OP, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1, 1'b1, "sat");
        idle(1'b1, "sat_drain");
        check("sat_count_const", 32'(count), 32'h0000_FFFF);
        check("sat_err_const", 32'(err), 32'd0);
        $display("saturation run: %0d words written, count=%h addr=%h", 65537, count, addr);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the datapath immediate generator: accepts decoded instruction fields (opcode, registers, functs, full 32-bit immediate) and packs them into a 32-bit RV32I instruction word.
- Checks each immediate for range and alignment, then writes accepted words sequentially into instruction memory.
- Used by the test/program-loader path to build programs in-system without an external assembler.
- One input handshake, one registered output stage with memory backpressure, an address counter and sticky error reporting.

Parameters:
- BASE_ADDR, 32'h0040_0000, first word address written after reset or restart.
- ADDR_STEP, 4, byte increment per written word.

Ports:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  synchronous, active-low reset.
- iRestart  in  1  synchronous restart of address, count and error (active-high).
- iValid  in  1  input fields valid.
- oReady  out  1  encoder can accept fields this cycle.
- iOpcode  in  7  RV32I opcode (OPC_* constants from Parametros.v).
- iRd  in  5  destination register.
- iRs1  in  5  source register 1.
- iRs2  in  5  source register 2.
- iFunct3  in  3  funct3.
- iFunct7  in  7  funct7 (R-type only).
- iImm  in  32  signed byte offset/value; for LUI, the full 32-bit value.
- oWrEn  out  1  word pending for memory.
- oAddr  out  32  write address.
- oWord  out  32  encoded instruction.
- iMemReady  in  1  memory accepts write this cycle.
- oCount  out  16  words written since reset/restart, saturating at 16'hFFFF.
- oErr  out  1  sticky: at least one rejected input.
- oErrOp  out  7  opcode of the first rejected input.

Behaviour:
- Reset (iRST=0 at an edge):
  - oWrEn=0, oAddr=BASE_ADDR, oWord=0, oCount=0, oErr=0, oErrOp=0.
  - Any pending word is discarded. Reset overrides all other inputs, including iRestart.
- Output stage: one register, FULL when oWrEn=1.
  - oReady = !oWrEn || iMemReady (combinational).
- Input transfer occurs on an edge where iValid && oReady.
  - A valid word is registered at that edge, so oWrEn=1 from the next cycle (latency 1).
- Write completes on an edge where oWrEn && iMemReady.
  - oAddr += ADDR_STEP and oCount += 1 (saturating) at that edge.
  - oWrEn clears unless a new valid word is loaded at the same edge (back-to-back, full throughput).
- While oWrEn=1, oWord and oAddr hold stable until iMemReady is asserted.
- Encoding, by opcode:
  - R-type 0110011: {funct7, rs2, rs1, funct3, rd, op}
  - LOAD/OPIMM/JALR: {imm[11:0], rs1, funct3, rd, op}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - LUI: {imm[31:12], rd, op}
- Rejection rules (checked on iImm as signed 32-bit):
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - LUI: imm[11:0]≠0.
  - Any other opcode.
- On a rejected input:
  - The input is still consumed (handshake completes).
  - No word is loaded, so the output stage is unchanged; oAddr and oCount do not move.
  - oErr=1. oErrOp captures iOpcode only if oErr was 0.
- iRestart=1 at an edge (with iRST=1):
  - oAddr=BASE_ADDR, oCount=0, oErr=0, oErrOp=0, oWrEn=0 (pending word dropped).
  - Inputs presented that cycle are not accepted: oReady is forced to 0 while iRestart=1.
- Reset or restart mid-backpressure drops the word; memory must tolerate a withdrawn oWrEn.
- oAddr wraps modulo 2^32; no error is raised on wrap.

Test Plan:
- Encoding and address sequence: after reset, iMemReady=1, send addi x1,x0,5 (op 0010011, rd=1, f3=0, imm=5) then sw x2,4(x1) (op 0100011, rs1=1, rs2=2, f3=010, imm=4) on consecutive cycles -> oWord 0x00500093 @0x00400000, then 0x0020A223 @0x00400004; oReady stays 1; oCount=2.
- Jump and upper-immediate encoding: send lui x5 with imm=0x12345000, then jal x0 with imm=0 -> oWord 0x123452B7, then 0x0000006F.
- Backpressure: iMemReady=0 for 5 cycles with one word pending, iValid held high -> oReady=0; oWord/oAddr stable; oCount unchanged. Raise iMemReady -> pending word completes and the next word loads at the same edge.
- Range rejection: send addi imm=2048, then beq imm=6 (odd-halfword is fine) and beq imm=5 -> addi rejected (oErr=1, oErrOp=0010011); beq imm=6 written; beq imm=5 rejected; oErrOp still 0010011; oAddr advanced only once.
- Restart and reset: iRestart with a word pending under backpressure -> oWrEn=0 next cycle, oAddr=0x00400000, oErr=0, oCount=0; repeat with iRST=0 -> identical outputs; iRST=0 with iRestart=1 -> reset values.
- Saturation and wrap: force oCount to 0xFFFF and oAddr to 0xFFFFFFFC, then write one word -> oCount stays 0xFFFF, oAddr=0x00000000, oErr unchanged.
